// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit and receive blocks.
//   CLK_HZ_DEFAULT, BIT_RATE_DEFAULT : default clock and line rates
//   cycles_per_bit()                 : clock cycles per line bit (truncated)
//   tx_state_e                       : transmitter FSM state encoding
package uart_pkg;

    localparam int CLK_HZ_DEFAULT   = 100_000_000;
    localparam int BIT_RATE_DEFAULT = 115_200;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a registered occupancy count.
//   clk, rst          : clock, synchronous active-high reset (flushes contents)
//   wr_en, wr_data    : push request; ignored while full
//   rd_en, rd_data    : pop request; rd_data shows the head entry (fall-through)
//   full, empty       : occupancy flags derived from level
//   level             : entries currently stored
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two and >= 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             push, pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];

    // A full FIFO refuses the write even if a read frees a slot this cycle.
    assign push = wr_en && !full;
    assign pop  = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            level_d = level_q + (AW+1)'(1);
        end else if (pop && !push) begin
            level_d = level_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: buffered UART transmitter (start, LSB-first data, stop bits).
//   clk, rst    : clock, synchronous active-high reset
//   s_data      : byte to transmit, accepted when s_valid && s_ready
//   s_valid     : s_data valid
//   s_ready     : FIFO has room
//   uart_txd    : serial line, idle high, registered
//   tx_busy     : frame in progress or bytes queued, registered
//   fifo_level  : entries currently queued
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = CLK_HZ_DEFAULT,
    parameter int BIT_RATE     = BIT_RATE_DEFAULT,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PAYLOAD_BITS-1:0]       s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          uart_txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CPB = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int TW  = (CPB > 2) ? $clog2(CPB) : 1;
    localparam int BW  = $clog2(PAYLOAD_BITS + 1);

    localparam logic [TW-1:0] TIMER_LAST = TW'(CPB - 1);
    localparam logic [BW-1:0] DATA_LAST  = BW'(PAYLOAD_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_BITS - 1);

    if (CPB < 2) begin : g_bad_rate
        $error("uart_tx_stream: CLK_HZ/BIT_RATE must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_stream: STOP_BITS must be 1 or 2");
    end

    tx_state_e                 state_q, state_d;
    logic [TW-1:0]             timer_q, timer_d;
    logic [BW-1:0]             bit_cnt_q, bit_cnt_d;
    logic [PAYLOAD_BITS-1:0]   shreg_q, shreg_d;
    logic                      txd_q, txd_d;
    logic                      busy_q, busy_d;

    logic                      fifo_pop;
    logic [PAYLOAD_BITS-1:0]   fifo_head;
    logic                      fifo_full, fifo_empty;
    logic                      push_acc;
    logic                      bit_end;

    sync_fifo #(
        .WIDTH (PAYLOAD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (s_valid),
        .wr_data (s_data),
        .rd_en   (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign s_ready  = !fifo_full;
    assign push_acc = s_valid && !fifo_full;
    assign bit_end  = (timer_q == TIMER_LAST);
    assign uart_txd = txd_q;
    assign tx_busy  = busy_q;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        fifo_pop  = 1'b0;

        if (state_q != TX_IDLE) begin
            timer_d = bit_end ? '0 : timer_q + TW'(1);
        end

        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_head;
                    state_d  = TX_START;
                    timer_d  = '0;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_d   = TX_DATA;
                    bit_cnt_d = '0;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_cnt_q == DATA_LAST) begin
                        state_d   = TX_STOP;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        // Chain straight into the next frame when data is waiting.
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            shreg_d  = fifo_head;
                            state_d  = TX_START;
                        end else begin
                            state_d  = TX_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase

        // Line level follows the current state, so it trails the FSM by one edge.
        case (state_q)
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = shreg_q[0];
            default:  txd_d = 1'b1;
        endcase

        // Any pop moves the FSM to START, so the FIFO only needs checking
        // for the no-pop case: occupied now, or receiving a byte this edge.
        busy_d = (state_d != TX_IDLE) || !fifo_empty || push_acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= TX_IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
module tb_uart_tx_stream;

    localparam int CLK_HZ        = 16;
    localparam int BIT_RATE      = 2;
    localparam int STOP_BITS     = 2;
    localparam int CPB           = 8;
    localparam int FRAME_BITS    = 1 + 8 + STOP_BITS;
    localparam int FRAME_SAMPLES = FRAME_BITS * CPB;

    logic       clk;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       uart_txd;
    logic       tx_busy;
    logic [4:0] fifo_level;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    logic [7:0] exp_q[$];

    bit                    mon_active = 0;
    int                    mon_idx    = 0;
    int                    mon_gap    = 0;
    logic [FRAME_BITS-1:0] mon_frame;
    logic [7:0]            mon_byte;
    logic [7:0]            mon_exp;
    int                    frames_started = 0;
    int                    frames_done    = 0;
    bit                    b2b_mode       = 0;
    int                    b2b_first      = 0;

    uart_tx_stream #(
        .CLK_HZ       (CLK_HZ),
        .BIT_RATE     (BIT_RATE),
        .PAYLOAD_BITS (8),
        .STOP_BITS    (STOP_BITS),
        .FIFO_DEPTH   (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .uart_txd   (uart_txd),
        .tx_busy    (tx_busy),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Line monitor: decodes frames sampled on the falling edge and pops
    // the expected byte from the scoreboard when a start bit appears.
    always @(negedge clk) begin
        if (rst) begin
            mon_active = 0;
            mon_gap    = 0;
        end else begin
            if (!mon_active && uart_txd == 1'b0) begin
                chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                mon_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
                mon_frame = {{STOP_BITS{1'b1}}, mon_exp, 1'b0};
                if (b2b_mode && frames_started != b2b_first) begin
                    chk("b2b_gap", mon_gap, 0);
                end
                frames_started++;
                mon_gap    = 0;
                mon_idx    = 0;
                mon_byte   = 8'h00;
                mon_active = 1;
            end
            if (mon_active) begin
                chk("line_bit", 32'(uart_txd), 32'(mon_frame[mon_idx / CPB]));
                if ((mon_idx % CPB) == CPB / 2 && (mon_idx / CPB) >= 1 && (mon_idx / CPB) <= 8) begin
                    mon_byte[(mon_idx / CPB) - 1] = uart_txd;
                end
                mon_idx++;
                if (mon_idx == FRAME_SAMPLES) begin
                    chk("rx_byte", 32'(mon_byte), 32'(mon_exp));
                    mon_active = 0;
                    frames_done++;
                end
            end else begin
                mon_gap++;
            end
        end
    end

    task automatic push(input logic [7:0] b, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        s_data  = b;
        s_valid = 1'b1;
        while (!s_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("push_timeout", 32'(n < 2000), 32'd1);
        exp_q.push_back(b);
        @(posedge clk);
        #1;
        acc     = cyc;
        s_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_active || tx_busy) && n < 4000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, 32'(n < 4000), 32'd1);
    endtask

    task automatic wait_level_change(input logic [4:0] from);
        int n;
        n = 0;
        while (fifo_level == from && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic single_byte(input logic [7:0] b);
        int acc, n, fall, busy_cnt, f0;
        f0 = frames_done;
        push(b, acc);
        chk("busy_after_accept", 32'(tx_busy), 32'd1);
        n = 0;
        fall = 0;
        busy_cnt = 1;
        while (n < 300) begin
            @(posedge clk);
            #1;
            n++;
            if (uart_txd == 1'b0 && fall == 0) fall = n;
            if (tx_busy) busy_cnt++;
            else break;
        end
        chk("txd_fall_latency", fall, 2);
        chk("busy_cycles", busy_cnt, 1 + FRAME_SAMPLES);
        drain("single_drain");
        chk("single_frames", frames_done - f0, 1);
        chk("single_idle_txd", 32'(uart_txd), 32'd1);
    endtask

    initial begin
        int a, acc, f0;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txd", 32'(uart_txd), 32'd1);
        chk("rst_ready", 32'(s_ready), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_txd", 32'(uart_txd), 32'd1);

        single_byte(8'h01);
        single_byte(8'hA5);

        // Burst of 17 with s_valid effectively held high
        f0 = frames_done;
        b2b_first = frames_started;
        b2b_mode  = 1;
        for (int i = 0; i <= 16; i++) push(8'(i), acc);
        chk("burst_full_level", 32'(fifo_level), 32'd16);
        chk("burst_full_ready", 32'(s_ready), 32'd0);
        @(negedge clk);
        s_data  = 8'h11;
        s_valid = 1'b1;
        wait_level_change(5'd16);
        chk("full_pop_no_push", 32'(fifo_level), 32'd15);
        @(posedge clk);
        #1;
        chk("push_after_pop", 32'(fifo_level), 32'd16);
        exp_q.push_back(8'h11);
        s_valid = 1'b0;
        wait_level_change(5'd16);
        chk("level_dec", 32'(fifo_level), 32'd15);
        wait_level_change(5'd15);
        chk("level_dec2", 32'(fifo_level), 32'd14);
        drain("burst_drain");
        b2b_mode = 0;
        chk("burst_frames", frames_done - f0, 18);

        // Push on the exact pop edge with five entries queued
        push(8'h60, a);
        for (int i = 1; i < 6; i++) push(8'(8'h60 + i), acc);
        while (cyc < a + 88) begin
            @(posedge clk);
            #1;
        end
        chk("lvl_pre_pop", 32'(fifo_level), 32'd5);
        push(8'h66, acc);
        chk("pop_push_edge", acc - a, 89);
        chk("lvl_pop_push", 32'(fifo_level), 32'd5);
        drain("pp_drain");

        // Reset during data bit 3 of the second of four queued bytes
        push(8'h81, a);
        for (int i = 2; i <= 4; i++) push(8'(8'h80 + i), acc);
        while (cyc < a + 123) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_txd", 32'(uart_txd), 32'd1);
        chk("midrst_level", 32'(fifo_level), 32'd0);
        chk("midrst_busy", 32'(tx_busy), 32'd0);
        chk("midrst_ready", 32'(s_ready), 32'd1);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_txd", 32'(uart_txd), 32'd1);
        f0 = frames_done;
        push(8'h3C, acc);
        drain("rst_drain");
        chk("post_rst_frames", frames_done - f0, 1);

        // Random bytes with random spacing
        f0 = frames_done;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push(8'($urandom_range(0, 255)), acc);
        end
        drain("rand_drain");
        chk("rand_frames", frames_done - f0, 20);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
